wb_axi_fir_bridge: RTL and testbench

// - Wishbone slave -> AXI4-Lite master + AXI-Stream master/slave bridge.
// - Sits directly downstream of the user-area address decoder and serves the 0x300x_xxxx / 0x301x_xxxx windows.
// - Feeds an AXI accelerator (FIR / matmul):
//   - config registers over AXI-Lite;
//   - input samples over the SS (stream out) port;
//   - results back over the SM (stream in) port.
// - Single outstanding transaction; every Wishbone access gets exactly one ack.

---
 rtl/wb_axi_fir_bridge.sv | 191 +++++++++++++++++++
 tb/tb_wb_axi_fir_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_axi_fir_bridge.sv
// Wishbone slave that forwards accesses to an accelerator over AXI-Lite (config)
// and a pair of AXI-Streams (samples out, results in); one transaction at a time.
module wb_axi_fir_bridge #(
  parameter int AXIL_AW = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [AXIL_AW-1:0] axil_awaddr_o,
  output logic               axil_awvalid_o,
  input  logic               axil_awready_i,
  output logic [31:0]        axil_wdata_o,
  output logic [3:0]         axil_wstrb_o,
  output logic               axil_wvalid_o,
  input  logic               axil_wready_i,
  input  logic               axil_bvalid_i,
  output logic               axil_bready_o,
  output logic [AXIL_AW-1:0] axil_araddr_o,
  output logic               axil_arvalid_o,
  input  logic               axil_arready_i,
  input  logic [31:0]        axil_rdata_i,
  input  logic               axil_rvalid_i,
  output logic               axil_rready_o,
  output logic [31:0]        ss_tdata_o,
  output logic               ss_tlast_o,
  output logic               ss_tvalid_o,
  input  logic               ss_tready_i,
  input  logic [31:0]        sm_tdata_i,
  input  logic               sm_tlast_i,
  input  logic               sm_tvalid_i,
  output logic               sm_tready_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LW, S_LB, S_LR_A, S_LR_D, S_SS, S_SM, S_ACK
  } state_t;

  state_t              state_q, state_d;
  logic [AXIL_AW-1:0]  addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          sel_q, sel_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [31:0]         rdat_q, rdat_d;
  logic [31:0]         ss_data_q, ss_data_d;
  logic                ss_last_q, ss_last_d;
  logic                ack_q, ack_d;
  logic                aw_hs, w_hs;

  // Upper address bits are resolved by the upstream decoder; stream tlast carries no meaning here.
  logic unused_in;
  assign unused_in = ^{wbs_adr_i[31:AXIL_AW], sm_tlast_i};

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = rdat_q;
  assign axil_awaddr_o = addr_q;
  assign axil_araddr_o = addr_q;
  assign axil_wdata_o  = data_q;
  assign axil_wstrb_o  = sel_q;
  assign ss_tdata_o    = ss_data_q;
  assign ss_tlast_o    = ss_last_q;

  assign aw_hs = axil_awvalid_o & axil_awready_i;
  assign w_hs  = axil_wvalid_o & axil_wready_i;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    sel_d          = sel_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    cnt_d          = cnt_q;
    rdat_d         = rdat_q;
    ss_data_d      = ss_data_q;
    ss_last_d      = ss_last_q;
    axil_awvalid_o = 1'b0;
    axil_wvalid_o  = 1'b0;
    axil_bready_o  = 1'b0;
    axil_arvalid_o = 1'b0;
    axil_rready_o  = 1'b0;
    ss_tvalid_o    = 1'b0;
    sm_tready_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wbs_stb_i && wbs_cyc_i) begin
          addr_d    = wbs_adr_i[AXIL_AW-1:0];
          data_d    = wbs_dat_i;
          sel_d     = wbs_sel_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = '0;
          if (!wbs_adr_i[7]) begin
            state_d = wbs_we_i ? S_LW : S_LR_A;
          end else if (wbs_we_i && (wbs_adr_i[7:0] == 8'h80 || wbs_adr_i[7:0] == 8'h88)) begin
            ss_data_d = wbs_dat_i;
            ss_last_d = wbs_adr_i[3];
            state_d   = S_SS;
          end else if (!wbs_we_i && wbs_adr_i[7:0] == 8'h84) begin
            state_d = S_SM;
          end else begin
            if (!wbs_we_i) rdat_d = '0;
            state_d = S_ACK;
          end
        end
      end
      S_LW: begin
        axil_awvalid_o = !aw_done_q;
        axil_wvalid_o  = !w_done_q;
        aw_done_d      = aw_done_q | aw_hs;
        w_done_d       = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = S_LB;
      end
      S_LB: begin
        axil_bready_o = 1'b1;
        if (axil_bvalid_i) state_d = S_ACK;
      end
      S_LR_A: begin
        axil_arvalid_o = 1'b1;
        if (axil_arready_i) state_d = S_LR_D;
      end
      S_LR_D: begin
        axil_rready_o = 1'b1;
        if (axil_rvalid_i) begin
          rdat_d  = axil_rdata_i;
          state_d = S_ACK;
        end
      end
      S_SS: begin
        ss_tvalid_o = 1'b1;
        if (ss_tready_i) state_d = S_ACK;
      end
      S_SM: begin
        sm_tready_o = 1'b1;
        if (sm_tvalid_i) begin
          rdat_d  = sm_tdata_i;
          state_d = S_ACK;
        end else if (cnt_q == CNT_MAX) begin
          rdat_d  = 32'hFFFF_FFFF;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ack_d = (state_d == S_ACK);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      rdat_q    <= '0;
      ss_data_q <= '0;
      ss_last_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      rdat_q    <= rdat_d;
      ss_data_q <= ss_data_d;
      ss_last_q <= ss_last_d;
      ack_q     <= ack_d;
    end
  end

endmodule

// File: tb/tb_wb_axi_fir_bridge.sv
// Scoreboard bench for wb_axi_fir_bridge: stimulus pushes expectations, negedge monitors pop and compare.
module tb_wb_axi_fir_bridge;

  localparam int AW = 12;
  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst;
  logic stb, cyc, we;
  logic [3:0] sel;
  logic [31:0] wdat, adr;
  logic ack;
  logic [31:0] rdat;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] ss_tdata, sm_tdata;
  logic ss_tlast, ss_tvalid, ss_tready;
  logic sm_tlast, sm_tvalid, sm_tready;

  always #5 clk = ~clk;

  wb_axi_fir_bridge #(.AXIL_AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .axil_awaddr_o(awaddr), .axil_awvalid_o(awvalid), .axil_awready_i(awready),
    .axil_wdata_o(wdata), .axil_wstrb_o(wstrb), .axil_wvalid_o(wvalid), .axil_wready_i(wready),
    .axil_bvalid_i(bvalid), .axil_bready_o(bready),
    .axil_araddr_o(araddr), .axil_arvalid_o(arvalid), .axil_arready_i(arready),
    .axil_rdata_i(rdata), .axil_rvalid_i(rvalid), .axil_rready_o(rready),
    .ss_tdata_o(ss_tdata), .ss_tlast_o(ss_tlast), .ss_tvalid_o(ss_tvalid), .ss_tready_i(ss_tready),
    .sm_tdata_i(sm_tdata), .sm_tlast_i(sm_tlast), .sm_tvalid_i(sm_tvalid), .sm_tready_o(sm_tready)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Expected responses
  logic [32:0]   ack_exp[$];   // {check_data, data}
  logic [AW-1:0] aw_exp[$];
  logic [35:0]   w_exp[$];     // {strb, data}
  logic [AW-1:0] ar_exp[$];
  logic [32:0]   ss_exp[$];    // {last, data}

  // Slave responder knobs
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [31:0] r_val = '0;
  bit ss_toggle = 0;

  initial begin
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = '0; ss_tready = 1;
    forever begin
      @(posedge clk); #1;
      if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end else begin awready = 0; aw_cnt = 0; end
      if (wvalid)  begin wready  = (w_cnt >= w_dly);   w_cnt++;  end else begin wready = 0;  w_cnt = 0;  end
      if (bready)  begin bvalid  = (b_cnt >= b_dly);   b_cnt++;  end else begin bvalid = 0;  b_cnt = 0;  end
      if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end else begin arready = 0; ar_cnt = 0; end
      if (rready)  begin rvalid  = (r_cnt >= r_dly);   r_cnt++;  end else begin rvalid = 0;  r_cnt = 0;  end
      rdata = rvalid ? r_val : 32'h0;
      ss_tready = ss_toggle ? ~ss_tready : 1'b1;
    end
  end

  // Monitors
  always @(negedge clk) begin
    if (ack) begin
      if (ack_exp.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
      else begin
        logic [32:0] e;
        e = ack_exp.pop_front();
        if (e[32]) check("wb_rdata", rdat, e[31:0]);
      end
    end
    if (awvalid && awready) begin
      if (aw_exp.size() == 0) check("unexpected_aw", 32'd1, 32'd0);
      else check("awaddr", 32'(awaddr), 32'(aw_exp.pop_front()));
    end
    if (wvalid && wready) begin
      if (w_exp.size() == 0) check("unexpected_w", 32'd1, 32'd0);
      else begin
        logic [35:0] e;
        e = w_exp.pop_front();
        check("wdata", wdata, e[31:0]);
        check("wstrb", 32'(wstrb), 32'(e[35:32]));
      end
    end
    if (arvalid && arready) begin
      if (ar_exp.size() == 0) check("unexpected_ar", 32'd1, 32'd0);
      else check("araddr", 32'(araddr), 32'(ar_exp.pop_front()));
    end
    // Every valid cycle is compared, so data held across tready=0 must stay on the expected word.
    if (ss_tvalid) begin
      if (ss_exp.size() == 0) check("unexpected_ss", 32'd1, 32'd0);
      else begin
        check("ss_tdata", ss_tdata, ss_exp[0][31:0]);
        check("ss_tlast", 32'(ss_tlast), 32'(ss_exp[0][32]));
        if (ss_tready) void'(ss_exp.pop_front());
      end
    end
  end

  // Called at #1 after a posedge; returns at #1 after a posedge with the bridge idle.
  task automatic wb_xfer(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic chk_rd, input logic [31:0] exp_rd,
                         input int exp_lat);
    int n;
    bit got;
    ack_exp.push_back({chk_rd, exp_rd});
    stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
    n = 0; got = 0;
    while (!got && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (ack) got = 1;
    end
    stb = 0; cyc = 0; we = 0;
    if (!got) check({name, "_ack_timeout"}, 32'd0, 32'd1);
    else if (exp_lat > 0) check({name, "_latency"}, 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; wdat = 0; adr = 0;
    sm_tdata = 0; sm_tlast = 0; sm_tvalid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_ack", 32'(ack), 0);
    check("rst_dat", rdat, 0);
    check("rst_valids", 32'({awvalid, wvalid, arvalid, ss_tvalid}), 0);
    check("rst_readys", 32'({bready, rready, sm_tready}), 0);
    check("rst_ss_tdata", ss_tdata, 0);
    check("rst_ss_tlast", 32'(ss_tlast), 0);
    @(posedge clk); #1;

    // AXI-Lite write with awready delayed 2, bvalid delayed 1
    aw_dly = 2; b_dly = 1;
    aw_exp.push_back(12'h010); w_exp.push_back({4'hF, 32'h0000_0040});
    wb_xfer("lite_wr_slow", 1, 32'h3000_0010, 32'h0000_0040, 4'hF, 0, 0, 6);
    aw_dly = 0; b_dly = 0;

    // AXI-Lite read with rvalid delayed 3
    r_dly = 3; r_val = 32'h0000_0004;
    ar_exp.push_back(12'h000);
    wb_xfer("lite_rd_slow", 0, 32'h3000_0000, 0, 4'hF, 1, 32'h0000_0004, 6);
    r_dly = 0;

    // Stream push with toggling tready
    ss_toggle = 1;
    ss_exp.push_back({1'b0, 32'd1}); wb_xfer("ss1", 1, 32'h3000_0080, 32'd1, 4'hF, 0, 0, -1);
    ss_exp.push_back({1'b0, 32'd2}); wb_xfer("ss2", 1, 32'h3000_0080, 32'd2, 4'hF, 0, 0, -1);
    ss_exp.push_back({1'b0, 32'd3}); wb_xfer("ss3", 1, 32'h3000_0080, 32'd3, 4'hF, 0, 0, -1);
    ss_exp.push_back({1'b1, 32'd4}); wb_xfer("ss4", 1, 32'h3000_0088, 32'd4, 4'hF, 0, 0, -1);
    ss_toggle = 0;

    // Stream pop: timeout, then data present
    wb_xfer("sm_timeout", 0, 32'h3000_0084, 0, 4'hF, 1, 32'hFFFF_FFFF, TIMEOUT + 1);
    sm_tvalid = 1; sm_tdata = 32'h0000_1234;
    wb_xfer("sm_data", 0, 32'h3000_0084, 0, 4'hF, 1, 32'h0000_1234, 2);
    sm_tvalid = 0; sm_tdata = 0;

    // Unmapped accesses
    wb_xfer("unmap_wr", 1, 32'h3000_00C0, 32'hCAFE_F00D, 4'hF, 0, 0, 1);
    wb_xfer("unmap_rd", 0, 32'h3000_00C0, 0, 4'hF, 1, 32'h0, 1);
    wb_xfer("unmap_wr84", 1, 32'h3000_0084, 32'h5555_AAAA, 4'hF, 0, 0, 1);
    r_val = 32'h0BAD_F00D; ar_exp.push_back(12'h008);
    wb_xfer("lite_rd_nz", 0, 32'h3000_0008, 0, 4'hF, 1, 32'h0BAD_F00D, 3);
    wb_xfer("unmap_rd80", 0, 32'h3000_0080, 0, 4'hF, 1, 32'h0, 1);

    // Minimum-latency paths
    aw_exp.push_back(12'h020); w_exp.push_back({4'h3, 32'hA5A5_5A5A});
    wb_xfer("lite_wr_min", 1, 32'h3010_0020, 32'hA5A5_5A5A, 4'h3, 0, 0, 3);
    r_val = 32'hDEAD_BEEF; ar_exp.push_back(12'h004);
    wb_xfer("lite_rd_min", 0, 32'h3000_0004, 0, 4'hF, 1, 32'hDEAD_BEEF, 3);
    ss_exp.push_back({1'b1, 32'h0000_0077});
    wb_xfer("ss_min", 1, 32'h3000_0088, 32'h0000_0077, 4'hF, 0, 0, 2);

    // Reset in the middle of a write with awready held low
    aw_dly = 100000;
    w_exp.push_back({4'hF, 32'h1111_2222});
    stb = 1; cyc = 1; we = 1; adr = 32'h3000_0030; wdat = 32'h1111_2222; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_lw_awvalid", 32'(awvalid), 1);
    rst = 1; stb = 0; cyc = 0; we = 0;
    @(posedge clk); #1;
    rst = 0;
    check("rst_lw_awvalid", 32'(awvalid), 0);
    check("rst_lw_wvalid", 32'(wvalid), 0);
    check("rst_lw_ack", 32'(ack), 0);
    check("rst_lw_ss_tdata", ss_tdata, 0);
    check("rst_lw_ss_tlast", 32'(ss_tlast), 0);
    check("rst_lw_dat", rdat, 0);
    aw_dly = 0;
    @(posedge clk); #1;
    aw_exp.push_back(12'h034); w_exp.push_back({4'hC, 32'h3333_4444});
    wb_xfer("post_rst_wr", 1, 32'h3000_0034, 32'h3333_4444, 4'hC, 0, 0, 3);

    repeat (5) @(posedge clk);
    #1;
    check("ack_exp_empty", 32'(ack_exp.size()), 0);
    check("aw_exp_empty", 32'(aw_exp.size()), 0);
    check("w_exp_empty", 32'(w_exp.size()), 0);
    check("ar_exp_empty", 32'(ar_exp.size()), 0);
    check("ss_exp_empty", 32'(ss_exp.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
